fetch_sequencer: RTL



---
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: FETCH/DECODE/EXECUTE control unit for the 4-bit CPU.
// Owns the PC, addresses the synchronous instruction ROM and issues one-cycle
// datapath strobes per instruction until HALT.
// Optional feature macro: FETCH_SEQ_SINGLE_STEP_EN (adds step input and PAUSE state).
module fetch_sequencer #(
    parameter logic [3:0] RESET_PC   = 4'd0,
    parameter bit         AUTO_START = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic [3:0] pc_addr,
    input  logic [7:0] instruction_in,
    input  logic       zero_flag,
    output logic       reg_we,
    output logic       reg_dst,
    output logic [1:0] alu_op,
    output logic       alu_src_imm,
    output logic [3:0] imm,
    output logic       busy,
    output logic       halted,
    output logic       illegal_op
);

    localparam int unsigned PC_W  = 4;
    localparam int unsigned IR_W  = 8;
    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_MOV0 = 4'b0101;
    localparam logic [OPC_W-1:0] OP_MOV1 = 4'b0110;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_AND  = 4'b1010;
    localparam logic [OPC_W-1:0] OP_OR   = 4'b1011;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'b1101;
    localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [IR_W-1:0]   ir;
    logic [OPC_W-1:0]  dec_opc;
    logic              dec_we;
    logic              dec_dst;
    logic [1:0]        dec_op;
    logic              dec_src_imm;
    logic              dec_illegal;

    assign pc_addr = pc;
    assign imm     = ir[3:0];

    // Decode the ROM word while in DECODE so strobes are registered into EXECUTE together with IR.
    always_comb begin
        dec_opc     = instruction_in[7:4];
        dec_we      = 1'b0;
        dec_dst     = 1'b0;
        dec_op      = 2'b00;
        dec_src_imm = 1'b0;
        dec_illegal = 1'b0;
        case (dec_opc)
            OP_NOP, OP_JMP, OP_JZ, OP_HALT: ;
            OP_MOV0: begin
                dec_we      = 1'b1;
                dec_src_imm = 1'b1;
            end
            OP_MOV1: begin
                dec_we      = 1'b1;
                dec_dst     = 1'b1;
                dec_src_imm = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec_we = 1'b1;
                dec_op = dec_opc[1:0];
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Sequencer: state, PC, IR and all registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ir          <= 8'h00;
            reg_we      <= 1'b0;
            reg_dst     <= 1'b0;
            alu_op      <= 2'b00;
            alu_src_imm <= 1'b0;
            illegal_op  <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            reg_we      <= 1'b0;
            reg_dst     <= 1'b0;
            alu_op      <= 2'b00;
            alu_src_imm <= 1'b0;
            illegal_op  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (AUTO_START || start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir          <= instruction_in;
                    reg_we      <= dec_we;
                    reg_dst     <= dec_dst;
                    alu_op      <= dec_op;
                    alu_src_imm <= dec_src_imm;
                    illegal_op  <= dec_illegal;
                    state       <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (ir[7:4])
                        OP_JMP:  pc <= ir[3:0];
                        OP_JZ:   pc <= zero_flag ? ir[3:0] : PC_W'(pc + 4'd1);
                        OP_HALT: ;
                        default: pc <= PC_W'(pc + 4'd1);
                    endcase
                    if (ir[7:4] == OP_HALT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
`ifdef FETCH_SEQ_SINGLE_STEP_EN
                        state <= S_PAUSE;
                        busy  <= 1'b0;
`else
                        state <= S_FETCH;
`endif
                    end
                end
                S_HALT: ;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
